// File: rtl/regfile_2r1w.sv
// Register file with one write port and two registered read ports.
// Optional hardwired-zero register 0 and optional same-edge write-to-read forwarding.
module regfile_2r1w #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int AW       = $clog2(DEPTH),
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic             re0,
    input  logic [AW-1:0]    ra0,
    input  logic             re1,
    input  logic [AW-1:0]    ra1,
    output logic [WIDTH-1:0] op1,
    output logic [WIDTH-1:0] op2,
    output logic             v1,
    output logic             v2
);
    localparam int          NUM_RD  = 2;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0]  regs;
    logic                         wr_ok;
    logic [NUM_RD-1:0]            rd_en;
    logic [NUM_RD-1:0]            rd_vld;
    logic [NUM_RD-1:0][AW-1:0]    rd_addr;
    logic [NUM_RD-1:0][WIDTH-1:0] rd_d;
    logic [NUM_RD-1:0][WIDTH-1:0] rd_q;

    // Address maps to real, writable storage (DEPTH need not be a power of two).
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_W) && !(ZERO_REG && (a == '0));
    endfunction

    assign wr_ok   = we && addr_ok(wa);
    assign rd_en   = {re1, re0};
    assign rd_addr = {ra1, ra0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
        end else if (wr_ok) begin
            regs[wa] <= wd;
        end
    end

    // Unmapped and zero-register addresses return zero; forwarding only from a write that lands.
    always_comb begin
        rd_d = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (addr_ok(rd_addr[p])) begin
                if (BYPASS && wr_ok && (wa == rd_addr[p])) rd_d[p] = wd;
                else                                       rd_d[p] = regs[rd_addr[p]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q   <= '0;
            rd_vld <= '0;
        end else begin
            rd_vld <= rd_en;
            for (int p = 0; p < NUM_RD; p++) begin
                if (rd_en[p]) rd_q[p] <= rd_d[p];
            end
        end
    end

    assign op1 = rd_q[0];
    assign op2 = rd_q[1];
    assign v1  = rd_vld[0];
    assign v2  = rd_vld[1];
endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: instance A (DEPTH 8, zero reg, forwarding) and
// instance B (DEPTH 6, no zero reg, no forwarding) share stimulus.
module tb_regfile_2r1w;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         we, re0, re1;
    logic [2:0]   wa, ra0, ra1;
    logic [W-1:0] wd;
    logic [W-1:0] a_op1, a_op2, b_op1, b_op2;
    logic         a_v1, a_v2, b_v1, b_v2;

    always #5 clk = ~clk;

    regfile_2r1w #(.WIDTH(W), .DEPTH(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
        .re0(re0), .ra0(ra0), .re1(re1), .ra1(ra1),
        .op1(a_op1), .op2(a_op2), .v1(a_v1), .v2(a_v2)
    );

    regfile_2r1w #(.WIDTH(W), .DEPTH(6), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
        .re0(re0), .ra0(ra0), .re1(re1), .ra1(ra1),
        .op1(b_op1), .op2(b_op2), .v1(b_v1), .v2(b_v2)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: index 0 = instance A, 1 = instance B.
    logic [W-1:0] mem  [2][8];
    logic [W-1:0] m_op [2][2];
    logic         m_v  [2][2];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int a = 0; a < 8; a++) mem[c][a] = '0;
            for (int p = 0; p < 2; p++) begin
                m_op[c][p] = '0;
                m_v[c][p]  = 1'b0;
            end
        end
    endtask

    // Apply the behavioural rules for the inputs currently driven, as one clock edge.
    task automatic model_edge();
        int depth, a;
        bit zr, bp, wok, rok, en;
        for (int c = 0; c < 2; c++) begin
            depth = (c == 0) ? 8 : 6;
            zr    = (c == 0);
            bp    = (c == 0);
            wok   = we && (int'(wa) < depth) && !(zr && wa == 0);
            for (int p = 0; p < 2; p++) begin
                en = (p == 0) ? re0 : re1;
                a  = (p == 0) ? int'(ra0) : int'(ra1);
                m_v[c][p] = en;
                if (en) begin
                    rok = (a < depth) && !(zr && a == 0);
                    if (!rok)                     m_op[c][p] = '0;
                    else if (bp && wok && wa == a) m_op[c][p] = wd;
                    else                          m_op[c][p] = mem[c][a];
                end
            end
            if (wok) mem[c][wa] = wd;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".A.op1"}, a_op1, m_op[0][0]);
        chk({tag, ".A.op2"}, a_op2, m_op[0][1]);
        chk({tag, ".A.v1"},  {31'b0, a_v1}, {31'b0, m_v[0][0]});
        chk({tag, ".A.v2"},  {31'b0, a_v2}, {31'b0, m_v[0][1]});
        chk({tag, ".B.op1"}, b_op1, m_op[1][0]);
        chk({tag, ".B.op2"}, b_op2, m_op[1][1]);
        chk({tag, ".B.v1"},  {31'b0, b_v1}, {31'b0, m_v[1][0]});
        chk({tag, ".B.v2"},  {31'b0, b_v2}, {31'b0, m_v[1][1]});
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".A.op1"}, a_op1, '0);
        chk({tag, ".A.op2"}, a_op2, '0);
        chk({tag, ".A.v1"},  {31'b0, a_v1}, '0);
        chk({tag, ".A.v2"},  {31'b0, a_v2}, '0);
        chk({tag, ".B.op1"}, b_op1, '0);
        chk({tag, ".B.op2"}, b_op2, '0);
        chk({tag, ".B.v1"},  {31'b0, b_v1}, '0);
        chk({tag, ".B.v2"},  {31'b0, b_v2}, '0);
    endtask

    task automatic cycle(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    typedef struct {
        logic         we;
        logic [2:0]   wa;
        logic [W-1:0] wd;
        logic         re0;
        logic [2:0]   ra0;
        logic         re1;
        logic [2:0]   ra1;
        logic [W-1:0] a1, a2;
        logic         av1, av2;
        logic [W-1:0] b1, b2;
        logic         bv1, bv2;
    } vec_t;

    localparam int NV = 16;
    vec_t tbl [NV];

    function automatic vec_t mk(
        input logic w, input logic [2:0] wadr, input logic [W-1:0] wdat,
        input logic r0, input logic [2:0] adr0, input logic r1, input logic [2:0] adr1,
        input logic [W-1:0] a1, input logic [W-1:0] a2, input logic av1, input logic av2,
        input logic [W-1:0] b1, input logic [W-1:0] b2, input logic bv1, input logic bv2);
        vec_t v;
        v.we = w;   v.wa = wadr; v.wd = wdat;
        v.re0 = r0; v.ra0 = adr0; v.re1 = r1; v.ra1 = adr1;
        v.a1 = a1;  v.a2 = a2;   v.av1 = av1; v.av2 = av2;
        v.b1 = b1;  v.b2 = b2;   v.bv1 = bv1; v.bv2 = bv2;
        return v;
    endfunction

    initial begin
        //            we wa wd            re0 ra0 re1 ra1  A.op1         A.op2         v1 v2  B.op1         B.op2         v1 v2
        tbl[0]  = mk(0, 0, 32'h0,         1, 3, 1, 3, 32'h0,         32'h0,         1, 1, 32'h0,         32'h0,         1, 1);
        tbl[1]  = mk(1, 1, 32'h0005_0045, 0, 0, 0, 0, 32'h0,         32'h0,         0, 0, 32'h0,         32'h0,         0, 0);
        tbl[2]  = mk(0, 0, 32'h0,         1, 1, 1, 1, 32'h0005_0045, 32'h0005_0045, 1, 1, 32'h0005_0045, 32'h0005_0045, 1, 1);
        tbl[3]  = mk(1, 0, 32'hDEAD_BEEF, 0, 0, 0, 0, 32'h0005_0045, 32'h0005_0045, 0, 0, 32'h0005_0045, 32'h0005_0045, 0, 0);
        tbl[4]  = mk(0, 0, 32'h0,         1, 0, 0, 0, 32'h0,         32'h0005_0045, 1, 0, 32'hDEAD_BEEF, 32'h0005_0045, 1, 0);
        tbl[5]  = mk(1, 2, 32'h11,        0, 0, 0, 0, 32'h0,         32'h0005_0045, 0, 0, 32'hDEAD_BEEF, 32'h0005_0045, 0, 0);
        tbl[6]  = mk(1, 2, 32'h0005_1F15, 1, 2, 1, 2, 32'h0005_1F15, 32'h0005_1F15, 1, 1, 32'h11,        32'h11,        1, 1);
        tbl[7]  = mk(0, 0, 32'h0,         1, 2, 0, 0, 32'h0005_1F15, 32'h0005_1F15, 1, 0, 32'h0005_1F15, 32'h11,        1, 0);
        tbl[8]  = mk(1, 7, 32'hCAFE_F00D, 0, 0, 0, 0, 32'h0005_1F15, 32'h0005_1F15, 0, 0, 32'h0005_1F15, 32'h11,        0, 0);
        tbl[9]  = mk(0, 0, 32'h0,         1, 7, 1, 5, 32'hCAFE_F00D, 32'h0,         1, 1, 32'h0,         32'h0,         1, 1);
        tbl[10] = mk(0, 0, 32'h0,         1, 6, 1, 1, 32'h0,         32'h0005_0045, 1, 1, 32'h0,         32'h0005_0045, 1, 1);
        tbl[11] = mk(1, 3, 32'h33,        1, 3, 1, 6, 32'h33,        32'h0,         1, 1, 32'h0,         32'h0,         1, 1);
        tbl[12] = mk(1, 4, 32'hAAAA,      0, 0, 0, 0, 32'h33,        32'h0,         0, 0, 32'h0,         32'h0,         0, 0);
        tbl[13] = mk(1, 4, 32'hBBBB,      0, 0, 0, 0, 32'h33,        32'h0,         0, 0, 32'h0,         32'h0,         0, 0);
        tbl[14] = mk(0, 0, 32'h0,         1, 4, 1, 3, 32'hBBBB,      32'h33,        1, 1, 32'hBBBB,      32'h33,        1, 1);
        tbl[15] = mk(0, 0, 32'h0,         1, 0, 1, 0, 32'h0,         32'h0,         1, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 1);

        rst_n = 1'b0;
        we = 0; wa = 0; wd = 0; re0 = 0; ra0 = 0; re1 = 0; ra1 = 0;
        model_reset();
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, one clock edge each; model tracks state alongside.
        for (int i = 0; i < NV; i++) begin
            we = tbl[i].we; wa = tbl[i].wa; wd = tbl[i].wd;
            re0 = tbl[i].re0; ra0 = tbl[i].ra0; re1 = tbl[i].re1; ra1 = tbl[i].ra1;
            model_edge();
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.A.op1", i), a_op1, tbl[i].a1);
            chk($sformatf("vec%0d.A.op2", i), a_op2, tbl[i].a2);
            chk($sformatf("vec%0d.A.v", i), {30'b0, a_v1, a_v2}, {30'b0, tbl[i].av1, tbl[i].av2});
            chk($sformatf("vec%0d.B.op1", i), b_op1, tbl[i].b1);
            chk($sformatf("vec%0d.B.op2", i), b_op2, tbl[i].b2);
            chk($sformatf("vec%0d.B.v", i), {30'b0, b_v1, b_v2}, {30'b0, tbl[i].bv1, tbl[i].bv2});
        end

        // Fill every address, then drop reset between edges with a write and reads pending.
        re0 = 0; re1 = 0;
        for (int a = 0; a < 8; a++) begin
            we = 1; wa = 3'(a); wd = $urandom | 32'h1;
            cycle($sformatf("fill%0d", a));
        end
        we = 0; re0 = 1; ra0 = 5; re1 = 1; ra1 = 1;
        cycle("prefill_read");
        we = 1; wa = 2; wd = 32'h1234_5678; ra0 = 2; ra1 = 3;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        check_zero("rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        we = 0;
        for (int a = 0; a < 8; a++) begin
            re0 = 1; ra0 = 3'(a); re1 = 1; ra1 = 3'(7 - a);
            cycle($sformatf("post_rst%0d", a));
        end

        // Randomized traffic against the model, with reads biased onto the write address.
        for (int n = 0; n < 400; n++) begin
            we  = 1'($urandom_range(0, 1));
            wa  = 3'($urandom_range(0, 7));
            wd  = $urandom;
            re0 = 1'($urandom_range(0, 1));
            re1 = 1'($urandom_range(0, 1));
            ra0 = ($urandom_range(0, 2) == 0) ? wa : 3'($urandom_range(0, 7));
            ra1 = ($urandom_range(0, 2) == 0) ? wa : 3'($urandom_range(0, 7));
            cycle($sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_2r1w.md
REGFILE_2R1W -- requirements
Module: regfile_2r1w

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning data bits per register.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning number of registers (2..256, need not be a power of two).
REQ-003 The block SHALL have parameter AW, default $clog2(DEPTH), meaning address width.
REQ-004 The block SHALL have parameter ZERO_REG, default 1, where 1 means register 0 reads as zero and ignores writes.
REQ-005 The block SHALL have parameter BYPASS, default 1, where 1 means a same-cycle write is forwarded to a matching read.
REQ-006 The block SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-007 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 The block SHALL have port we, input, 1 bit: write enable.
REQ-009 The block SHALL have port wa, input, AW bits: write address.
REQ-010 The block SHALL have port wd, input, WIDTH bits: write data.
REQ-011 The block SHALL have ports re0 and re1, inputs, 1 bit each: read enables for port 0 and port 1.
REQ-012 The block SHALL have ports ra0 and ra1, inputs, AW bits each: read addresses.
REQ-013 The block SHALL have ports op1 and op2, outputs, WIDTH bits each: registered read data for port 0 and port 1.
REQ-014 The block SHALL have ports v1 and v2, outputs, 1 bit each: read-data-valid flags for port 0 and port 1.

Function
REQ-015 The block SHALL store DEPTH registers of WIDTH bits and provide one write port and two independent read ports.
REQ-016 A write SHALL occur on the rising clk edge when we=1, updating reg[wa] with wd; reg[wa] is visible in storage from the next cycle.
REQ-017 The block SHALL ignore a write when wa>=DEPTH, or when ZERO_REG=1 and wa=0.
REQ-018 A read SHALL have 1-cycle latency: when re0=1 at edge N, op1 = reg[ra0] and v1=1 after edge N; likewise re1/ra1 for op2/v2.
REQ-019 When a read enable is 0 at an edge, that port's op SHALL hold its previous value and its v flag SHALL be 0 for that cycle.
REQ-020 A read SHALL return all-zeros with v=1 when its address is >=DEPTH, or when ZERO_REG=1 and the address is 0.
REQ-021 For a simultaneous write and read of the same valid, writable address at one edge: with BYPASS=1 the op SHALL capture wd; with BYPASS=0 it SHALL capture the pre-write contents.
REQ-022 Both read ports SHALL be able to read the same address in the same cycle, each returning identical data.
REQ-023 Read ports SHALL be fully independent; any combination of re0/re1 values is legal.
REQ-024 Consecutive writes to the same address SHALL be resolved last-write-wins, with one write per cycle.
REQ-025 The block SHALL contain no combinational path from any input to op1, op2, v1 or v2.

Reset
REQ-026 On rst_n=0, asynchronously and independent of clk, all registers, op1, op2, v1 and v2 SHALL clear to 0.
REQ-027 While rst_n=0, writes and reads SHALL be ignored.
REQ-028 After rst_n deasserts, the first rising edge SHALL perform normal operation.
REQ-029 Reset asserted mid-operation SHALL discard any write or read that has not yet reached a clock edge; no partial update is allowed.

Verification
REQ-030 Reset, then read addr 3 on both ports -> op1=op2=0, v1=v2=1 one cycle later.
REQ-031 Write 0x0005_0045 to addr 1, next cycle read ra0=1 and ra1=1 -> op1=op2=0x0005_0045, v1=v2=1.
REQ-032 Write 0xDEAD_BEEF to addr 0 with ZERO_REG=1, then read addr 0 -> op1=0; with ZERO_REG=0 -> op1=0xDEAD_BEEF.
REQ-033 Same-edge write 0x0005_1F15 to addr 2 and re0=1 with ra0=2 (old value 0x11) -> op1=0x0005_1F15 when BYPASS=1, 0x11 when BYPASS=0.
REQ-034 DEPTH=6: write to addr 7, then read addr 7 -> op1=0 with v1=1, and no stored register changes.
REQ-035 Pulse rst_n low between clock edges after filling all registers -> op1, op2, v1 and v2 drop to 0 immediately, and subsequent reads of every address return 0.
